// File: rtl/rpn_tokenizer.sv
// rtl/rpn_tokenizer.sv - ASCII byte stream to number/operator/eol/invalid tokens
// Digit runs accumulate in NUM; a non-digit terminator stays on the input until the number token drains.
module rpn_tokenizer #(
   parameter int NUM_WIDTH = 16,
   parameter bit SATURATE  = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [7:0]           in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic                 tok_valid,
   input  logic                 tok_ready,
   output logic [1:0]           tok_kind,
   output logic [NUM_WIDTH-1:0] tok_num,
   output logic [1:0]           tok_op,
   output logic                 tok_err
);

   typedef enum logic [1:0] {IDLE, NUM, EMIT} state_t;

   localparam logic [1:0] K_NUM = 2'd0;
   localparam logic [1:0] K_OP  = 2'd1;
   localparam logic [1:0] K_EOL = 2'd2;
   localparam logic [1:0] K_BAD = 2'd3;

   state_t               state, state_n;
   logic [NUM_WIDTH-1:0] acc, acc_n, num_n, acc_step;
   logic                 ovf, ovf_n, err_n;
   logic [1:0]           kind_n, op_n, op_code;
   logic                 is_digit, is_space, is_op, is_eol;
   logic [NUM_WIDTH+3:0] acc_x, prod;
   logic                 prod_ovf;

   always_comb begin
      is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
      is_space = (in_data == 8'h20) || (in_data == 8'h09);
      is_eol   = (in_data == 8'h0A) || (in_data == 8'h0D);
      is_op    = 1'b1;
      op_code  = 2'd0;
      case (in_data)
         8'h2B:   op_code = 2'd0;
         8'h2D:   op_code = 2'd1;
         8'h2A:   op_code = 2'd2;
         8'h2F:   op_code = 2'd3;
         default: is_op = 1'b0;
      endcase
   end

   // acc*10 + d with four guard bits; anything above NUM_WIDTH is an overflow
   always_comb begin
      acc_x    = {4'b0000, acc};
      prod     = (acc_x << 3) + (acc_x << 1) + {{NUM_WIDTH{1'b0}}, in_data[3:0]};
      prod_ovf = |prod[NUM_WIDTH+3:NUM_WIDTH];
      acc_step = (prod_ovf && SATURATE) ? {NUM_WIDTH{1'b1}} : prod[NUM_WIDTH-1:0];
   end

   always_comb begin
      state_n  = state;
      acc_n    = acc;
      ovf_n    = ovf;
      kind_n   = tok_kind;
      num_n    = tok_num;
      op_n     = tok_op;
      err_n    = tok_err;
      in_ready = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (is_digit) begin
                  acc_n   = NUM_WIDTH'(in_data[3:0]);
                  ovf_n   = 1'b0;
                  state_n = NUM;
               end else if (!is_space) begin
                  state_n = EMIT;
                  num_n   = '0;
                  op_n    = 2'd0;
                  err_n   = 1'b0;
                  if (is_op) begin
                     kind_n = K_OP;
                     op_n   = op_code;
                  end else if (is_eol) begin
                     kind_n = K_EOL;
                  end else begin
                     kind_n = K_BAD;
                     err_n  = 1'b1;
                  end
               end
            end
         end
         NUM: begin
            // Only digits and spaces are consumed; other terminators wait for IDLE
            in_ready = is_digit || is_space;
            if (in_valid) begin
               if (is_digit) begin
                  acc_n = acc_step;
                  ovf_n = ovf || prod_ovf;
               end else begin
                  state_n = EMIT;
                  kind_n  = K_NUM;
                  num_n   = acc;
                  op_n    = 2'd0;
                  err_n   = ovf;
               end
            end
         end
         EMIT: begin
            if (tok_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         acc      <= '0;
         ovf      <= 1'b0;
         tok_kind <= 2'd0;
         tok_num  <= '0;
         tok_op   <= 2'd0;
         tok_err  <= 1'b0;
      end else begin
         state    <= state_n;
         acc      <= acc_n;
         ovf      <= ovf_n;
         tok_kind <= kind_n;
         tok_num  <= num_n;
         tok_op   <= op_n;
         tok_err  <= err_n;
      end
   end

   assign tok_valid = (state == EMIT);

endmodule

// File: tb/tb_rpn_tokenizer.sv
// tb/tb_rpn_tokenizer.sv - directed bench for rpn_tokenizer
module tb_rpn_tokenizer;

   typedef struct packed {
      logic [1:0]  kind;
      logic [15:0] num;
      logic [1:0]  op;
      logic        err;
   } tok_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        tok_valid;
   logic        tok_ready = 1'b1;
   logic [1:0]  tok_kind;
   logic [15:0] tok_num;
   logic [1:0]  tok_op;
   logic        tok_err;

   logic [7:0]  in_data0 = 8'h00;
   logic        in_valid0 = 1'b0;
   logic        in_ready0;
   logic        tok_valid0;
   logic        tok_ready0 = 1'b1;
   logic [1:0]  tok_kind0;
   logic [15:0] tok_num0;
   logic [1:0]  tok_op0;
   logic        tok_err0;

   int   n_tests = 0;
   int   n_fail = 0;
   int   stall_cnt = 0;
   tok_t got_q[$];

   rpn_tokenizer #(.NUM_WIDTH(16), .SATURATE(1'b1)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_kind(tok_kind), .tok_num(tok_num),
      .tok_op(tok_op), .tok_err(tok_err)
   );

   rpn_tokenizer #(.NUM_WIDTH(16), .SATURATE(1'b0)) dut_wrap (
      .clk(clk), .rst(rst), .in_data(in_data0), .in_valid(in_valid0), .in_ready(in_ready0),
      .tok_valid(tok_valid0), .tok_ready(tok_ready0), .tok_kind(tok_kind0), .tok_num(tok_num0),
      .tok_op(tok_op0), .tok_err(tok_err0)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (!rst && tok_valid && tok_ready)
         got_q.push_back({tok_kind, tok_num, tok_op, tok_err});

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic tok_t mk(input int kind, input int num, input int op, input int err);
      return {kind[1:0], num[15:0], op[1:0], err[0]};
   endfunction

   task automatic chk_tok(input string tag, input int idx, input tok_t exp);
      tok_t t;
      t = (idx < got_q.size()) ? got_q[idx] : 'x;
      check(tag, 32'(t), 32'(exp));
   endtask

   task automatic send_str(input string s, input int budget);
      int  cyc;
      bit  done;
      for (int i = 0; i < s.len(); i++) begin
         in_data  = s[i];
         in_valid = 1'b1;
         cyc      = 0;
         done     = 1'b0;
         while (!done) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            else stall_cnt++;
            @(posedge clk);
            #1;
            cyc++;
            if (!done && cyc > budget) begin
               check("send_timeout", 32'd0, 32'd1);
               done = 1'b1;
            end
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic settle();
      repeat (5) @(posedge clk);
      #1;
   endtask

   initial begin
      string s;
      int    w;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_valid", 32'(tok_valid), 32'd0);
      check("rst_kind", 32'(tok_kind), 32'd0);
      check("rst_num", 32'(tok_num), 32'd0);
      check("rst_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;

      // 1: spaced expression
      got_q.delete();
      send_str("12 + 2 \n", 20);
      settle();
      check("t1_count", got_q.size(), 4);
      chk_tok("t1_tok0", 0, mk(0, 12, 0, 0));
      chk_tok("t1_tok1", 1, mk(1, 0, 0, 0));
      chk_tok("t1_tok2", 2, mk(0, 2, 0, 0));
      chk_tok("t1_tok3", 3, mk(2, 0, 0, 0));

      // 2: unspaced, number terminated by operator
      got_q.delete();
      stall_cnt = 0;
      s = "12+3*\015";
      send_str(s, 20);
      settle();
      check("t2_count", got_q.size(), 5);
      chk_tok("t2_tok0", 0, mk(0, 12, 0, 0));
      chk_tok("t2_tok1", 1, mk(1, 0, 0, 0));
      chk_tok("t2_tok2", 2, mk(0, 3, 0, 0));
      chk_tok("t2_tok3", 3, mk(1, 0, 2, 0));
      chk_tok("t2_tok4", 4, mk(2, 0, 0, 0));
      check("t2_stalls", stall_cnt, 6);

      // 3: overflow saturation
      got_q.delete();
      send_str("65535 65536 99999 \n", 40);
      settle();
      check("t3_count", got_q.size(), 4);
      chk_tok("t3_tok0", 0, mk(0, 65535, 0, 0));
      chk_tok("t3_tok1", 1, mk(0, 65535, 0, 1));
      chk_tok("t3_tok2", 2, mk(0, 65535, 0, 1));
      chk_tok("t3_tok3", 3, mk(2, 0, 0, 0));

      // 3b: wrapping build
      s = "65536 ";
      for (int i = 0; i < s.len(); i++) begin
         in_data0  = s[i];
         in_valid0 = 1'b1;
         @(negedge clk);
         check("t3b_ready", 32'(in_ready0), 32'd1);
         @(posedge clk);
         #1;
      end
      in_valid0 = 1'b0;
      w = 0;
      do begin
         @(negedge clk);
         w++;
      end while (!tok_valid0 && w < 10);
      check("t3b_valid", 32'(tok_valid0), 32'd1);
      check("t3b_kind", 32'(tok_kind0), 32'd0);
      check("t3b_num", 32'(tok_num0), 32'd0);
      check("t3b_err", 32'(tok_err0), 32'd1);
      settle();

      // 4: back-pressure
      got_q.delete();
      tok_ready = 1'b0;
      fork
         send_str("7 8 ", 60);
         begin
            w = 0;
            do begin
               @(negedge clk);
               w++;
            end while (!tok_valid && w < 20);
            for (int k = 0; k < 10; k++) begin
               check("t4_hold_valid", 32'(tok_valid), 32'd1);
               check("t4_hold_num", 32'(tok_num), 32'd7);
               check("t4_hold_ready", 32'(in_ready), 32'd0);
               @(posedge clk);
               #1;
               if (k < 9) @(negedge clk);
            end
            tok_ready = 1'b1;
         end
      join
      settle();
      check("t4_count", got_q.size(), 2);
      chk_tok("t4_tok0", 0, mk(0, 7, 0, 0));
      chk_tok("t4_tok1", 1, mk(0, 8, 0, 0));

      // 5: invalid character
      got_q.delete();
      send_str("4a\n", 20);
      settle();
      check("t5_count", got_q.size(), 3);
      chk_tok("t5_tok0", 0, mk(0, 4, 0, 0));
      chk_tok("t5_tok1", 1, mk(3, 0, 0, 1));
      chk_tok("t5_tok2", 2, mk(2, 0, 0, 0));

      // 6: reset discards a partial number
      got_q.delete();
      send_str("123", 20);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("t6_valid_after_rst", 32'(tok_valid), 32'd0);
      @(posedge clk);
      #1;
      send_str("5 ", 20);
      settle();
      check("t6_count", got_q.size(), 1);
      chk_tok("t6_tok0", 0, mk(0, 5, 0, 0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
